axi3_rd_sched: RTL and testbench

//  Round-robin job scheduler in front of the AXI3 read master engine. Shares one engine between NCH

---
 rtl/axi3_rd_sched_pkg.sv | 25 ++
 rtl/axi3_rd_sched_if.sv | 32 +++
 rtl/axi3_rd_sched_rr_arb.sv | 33 +++
 rtl/axi3_rd_sched.sv | 126 ++++++++++++
 tb/tb_axi3_rd_sched.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi3_rd_sched_pkg.sv
// Shared types and helpers for the AXI3 read-job scheduler.
package axi3_rd_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        DONE   = 2'd3
    } sched_state_t;

    localparam int BEAT_W = 15;

    // Beats the engine produces for a byte length: INCR16/8/4 word bursts, then word/half/byte singles.
    function automatic logic [BEAT_W-1:0] exp_beats(input logic [15:0] len);
        logic [BEAT_W-1:0] b;
        b = {1'b0, len[15:6], 4'b0000};
        b = b + BEAT_W'({len[5], 3'b000});
        b = b + BEAT_W'({len[4], 2'b00});
        b = b + BEAT_W'(len[3:2]);
        b = b + BEAT_W'(len[1]);
        b = b + BEAT_W'(len[0]);
        return b;
    endfunction

endpackage

// File: rtl/axi3_rd_sched_if.sv
// Requester and engine signals of the read-job scheduler, bundled for the top-level port.
interface axi3_rd_sched_if #(
    parameter int NCH        = 4,
    parameter int ADDR_WIDTH = 32
);
    localparam int CW = $clog2(NCH);

    logic [NCH-1:0]            req;
    logic [NCH*ADDR_WIDTH-1:0] req_addr;
    logic [NCH*16-1:0]         req_len;
    logic [NCH-1:0]            done;
    logic                      done_err;
    logic                      done_tmo;
    logic                      busy;
    logic [CW-1:0]             cur_ch;
    logic                      mst_begin;
    logic [ADDR_WIDTH-1:0]     addr_src;
    logic [15:0]               data_len;
    logic                      en_write;
    logic                      error;

    modport master (
        input  req, req_addr, req_len, en_write, error,
        output done, done_err, done_tmo, busy, cur_ch, mst_begin, addr_src, data_len
    );

    modport slave (
        output req, req_addr, req_len, en_write, error,
        input  done, done_err, done_tmo, busy, cur_ch, mst_begin, addr_src, data_len
    );

endinterface

// File: rtl/axi3_rd_sched_rr_arb.sv
// Combinational round-robin arbiter: first requesting index at or after ptr, wrapping.
module axi3_rd_sched_rr_arb #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_vec,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_vld
);

    int pos;

    // Walk from the farthest candidate back to ptr so the closest requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        pos       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= N) pos = pos - N;
            if (req_vec[pos]) begin
                grant      = '0;
                grant[pos] = 1'b1;
                grant_idx  = IW'(pos);
                grant_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi3_rd_sched.sv
// Round-robin job scheduler sharing one AXI3 read engine between NCH requesters.
//  state  | meaning
//  IDLE   | arbitrate; latch job on grant (len==0 skips the engine)
//  LAUNCH | pulse mst_begin, clear beat/timeout counters
//  BUSY   | count en_write beats until expected total or idle timeout
//  DONE   | pulse done[cur_ch] with err/tmo status
module axi3_rd_sched
    import axi3_rd_sched_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int TMO_W      = 16,
    parameter int TMO_CYC    = 4096
) (
    input logic             clk,
    input logic             rst_n,
    axi3_rd_sched_if.master bus
);

    localparam int               CW       = $clog2(NCH);
    localparam bit               TMO_EN   = (TMO_CYC != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);

    sched_state_t          state, state_nxt;
    logic [CW-1:0]         rr_ptr, cur_ch_q, grant_idx;
    logic [NCH-1:0]        grant, cur_oh, done_mask, req_masked;
    logic                  grant_vld;
    logic [ADDR_WIDTH-1:0] addr_q, addr_sel;
    logic [15:0]           len_q, len_sel;
    logic [BEAT_W-1:0]     exp_q, beat_cnt, beat_inc;
    logic [TMO_W-1:0]      tmo_cnt;
    logic                  err_base, job_err, tmo_flag, was_done;
    logic                  last_beat, tmo_hit;

    // The channel just completed sits out one IDLE cycle while its requester drops req.
    assign done_mask  = was_done ? cur_oh : '0;
    assign req_masked = bus.req & ~done_mask;

    axi3_rd_sched_rr_arb #(.N(NCH)) u_rr_arb (
        .req_vec   (req_masked),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign addr_sel  = bus.req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_sel   = bus.req_len[int'(grant_idx)*16 +: 16];
    assign beat_inc  = beat_cnt + BEAT_W'(1);
    assign last_beat = bus.en_write && (beat_inc == exp_q);
    assign tmo_hit   = TMO_EN && !bus.en_write && (tmo_cnt == TMO_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = (len_sel == 16'd0) ? DONE : LAUNCH;
            LAUNCH:  state_nxt = BUSY;
            BUSY:    if (last_beat || tmo_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            cur_ch_q <= '0;
            cur_oh   <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            exp_q    <= '0;
            beat_cnt <= '0;
            tmo_cnt  <= '0;
            err_base <= 1'b0;
            job_err  <= 1'b0;
            tmo_flag <= 1'b0;
            was_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            was_done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        cur_ch_q <= grant_idx;
                        cur_oh   <= grant;
                        addr_q   <= addr_sel;
                        len_q    <= len_sel;
                        exp_q    <= exp_beats(len_sel);
                        err_base <= bus.error;
                        job_err  <= 1'b0;
                        tmo_flag <= 1'b0;
                        rr_ptr   <= (grant_idx == CW'(NCH - 1)) ? '0 : grant_idx + CW'(1);
                    end
                end
                LAUNCH: begin
                    beat_cnt <= '0;
                    tmo_cnt  <= '0;
                end
                BUSY: begin
                    if (bus.en_write) begin
                        beat_cnt <= beat_inc;
                        tmo_cnt  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        if (tmo_hit) tmo_flag <= 1'b1;
                    end
                end
                default: ;
            endcase
            // An error flag already set at grant belongs to an earlier job.
            if ((state == LAUNCH || state == BUSY) && bus.error && !err_base)
                job_err <= 1'b1;
        end
    end

    assign bus.mst_begin = (state == LAUNCH);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE) ? cur_oh : '0;
    assign bus.done_err  = (state == DONE) && job_err;
    assign bus.done_tmo  = (state == DONE) && tmo_flag;
    assign bus.cur_ch    = cur_ch_q;
    assign bus.addr_src  = addr_q;
    assign bus.data_len  = len_q;

endmodule

// File: tb/tb_axi3_rd_sched.sv
// Directed bench for axi3_rd_sched: vector table of single jobs plus round-robin, error, timeout and reset sequences.
module tb_axi3_rd_sched;

    localparam int NCH     = 4;
    localparam int AW      = 32;
    localparam int TMO_CYC = 16;
    localparam int BOUND   = 20000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    axi3_rd_sched_if #(.NCH(NCH), .ADDR_WIDTH(AW)) bus ();

    axi3_rd_sched #(
        .NCH(NCH), .ADDR_WIDTH(AW), .TMO_W(16), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          ch;
        logic [31:0] addr;
        logic [15:0] len;
        int          beats;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    int n_vec = 0;
    int n_err = 0;

    int              r_lat, r_begin, r_ch, r_last;
    logic [NCH-1:0]  r_done;
    logic            r_err, r_tmo, r_busy;
    logic [31:0]     r_addr;
    logic [15:0]     r_len;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        bus.req      = '0;
        bus.en_write = 1'b0;
        bus.error    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Raise req on one channel and play the engine: beats start the cycle after mst_begin,
    // optional stall of stall_cyc idle cycles after stall_after beats, error raised after err_after beats.
    task automatic run_job(input int ch, input logic [31:0] addr, input logic [15:0] len,
                           input int nbeats, input int stall_after, input int stall_cyc,
                           input int err_after);
        int n, given, idle;
        bit started, fin;
        @(negedge clk);
        bus.req_addr[ch*AW +: AW] = addr;
        bus.req_len[ch*16 +: 16]  = len;
        bus.req[ch]               = 1'b1;
        n = 0; given = 0; idle = 0; started = 0; fin = 0;
        r_lat = -1; r_begin = 0; r_last = -1;
        while (!fin && n < BOUND) begin
            @(negedge clk);
            n++;
            if (bus.mst_begin) r_begin++;
            if (n == 1) begin
                r_addr = bus.addr_src;
                r_len  = bus.data_len;
                r_ch   = int'(bus.cur_ch);
                r_busy = bus.busy;
            end
            if (bus.done != '0) begin
                r_lat        = n;
                r_done       = bus.done;
                r_err        = bus.done_err;
                r_tmo        = bus.done_tmo;
                bus.req[ch]  = 1'b0;
                bus.en_write = 1'b0;
                fin          = 1;
            end else begin
                bus.en_write = 1'b0;
                if (err_after >= 0 && given >= err_after) bus.error = 1'b1;
                if (started && given < nbeats) begin
                    if (given == stall_after && idle < stall_cyc) idle++;
                    else begin
                        bus.en_write = 1'b1;
                        given++;
                        r_last = n;
                    end
                end
                if (bus.mst_begin) started = 1;
            end
        end
        check("job within bound", fin, 1);
        bus.req[ch] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_len  = '0;
        bus.en_write = 1'b0;
        bus.error    = 1'b0;

        // ch, addr, len, expected beats, expected grant-to-done cycles
        vecs[0]  = '{0, 32'h1000_0000, 16'd100,   25,    27};
        vecs[1]  = '{2, 32'h2000_0040, 16'd0,     0,     1};
        vecs[2]  = '{1, 32'h0000_0123, 16'd7,     3,     5};
        vecs[3]  = '{3, 32'hDEAD_BEE0, 16'd64,    16,    18};
        vecs[4]  = '{1, 32'h0000_0001, 16'd1,     1,     3};
        vecs[5]  = '{2, 32'h0000_0002, 16'd2,     1,     3};
        vecs[6]  = '{0, 32'h0000_0003, 16'd3,     2,     4};
        vecs[7]  = '{3, 32'h4000_0000, 16'd15,    5,     7};
        vecs[8]  = '{2, 32'h5000_0000, 16'd48,    12,    14};
        vecs[9]  = '{0, 32'h6000_0000, 16'd1000,  250,   252};
        vecs[10] = '{1, 32'hFFFF_FFFC, 16'hFFFF,  16385, 16387};

        #2 rst_n = 1'b0;
        #1;
        check("reset busy",      bus.busy, 0);
        check("reset done",      bus.done, 0);
        check("reset mst_begin", bus.mst_begin, 0);
        check("reset done_err",  bus.done_err, 0);
        check("reset done_tmo",  bus.done_tmo, 0);
        check("reset cur_ch",    bus.cur_ch, 0);
        check("reset addr_src",  bus.addr_src, 0);
        check("reset data_len",  bus.data_len, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_job(vecs[i].ch, vecs[i].addr, vecs[i].len, vecs[i].beats, -1, 0, -1);
            check($sformatf("v%0d latency", i), r_lat, vecs[i].lat);
            check($sformatf("v%0d done", i), r_done, 64'(1) << vecs[i].ch);
            check($sformatf("v%0d mst_begin count", i), r_begin, (vecs[i].len != 0) ? 1 : 0);
            check($sformatf("v%0d addr_src", i), r_addr, vecs[i].addr);
            check($sformatf("v%0d data_len", i), r_len, vecs[i].len);
            check($sformatf("v%0d cur_ch", i), r_ch, vecs[i].ch);
            check($sformatf("v%0d busy", i), r_busy, 1);
            check($sformatf("v%0d done_err", i), r_err, 0);
            check($sformatf("v%0d done_tmo", i), r_tmo, 0);
        end

        // Error rising during the job is reported; still high at the next grant, it is not.
        run_job(1, 32'h0000_0700, 16'd7, 3, -1, 0, 2);
        check("err job latency", r_lat, 5);
        check("err job done", r_done, 4'b0010);
        check("err job done_err", r_err, 1);
        run_job(3, 32'h0000_0800, 16'd4, 1, -1, 0, -1);
        check("err base done", r_done, 4'b1000);
        check("err base done_err", r_err, 0);
        bus.error = 1'b0;

        // 16-beat job stalls after 5 beats: tmo_cnt hits 15 on the 16th idle cycle, done follows.
        run_job(2, 32'h0000_0900, 16'd64, 16, 5, 100000, -1);
        check("tmo last beat", r_last, 6);
        check("tmo latency", r_lat, 23);
        check("tmo done", r_done, 4'b0100);
        check("tmo done_tmo", r_tmo, 1);
        // Final beat on the expiry cycle: completion wins.
        run_job(0, 32'h0000_0A00, 16'd64, 16, 15, 15, -1);
        check("tmo race latency", r_lat, 33);
        check("tmo race done_tmo", r_tmo, 0);
        // One idle cycle more than that: timeout.
        run_job(0, 32'h0000_0B00, 16'd64, 16, 15, 16, -1);
        check("tmo edge latency", r_lat, 33);
        check("tmo edge done_tmo", r_tmo, 1);

        // Round robin: all four request len=4, each drops req for one cycle after its done.
        do_reset();
        begin
            int k, last_done_n, idx;
            logic [NCH-1:0] drop;
            bit beat_next;
            k = 0; last_done_n = 0; drop = '0; beat_next = 0;
            for (int c = 0; c < NCH; c++) begin
                bus.req_len[c*16 +: 16]  = 16'd4;
                bus.req_addr[c*AW +: AW] = 32'h100 * (c + 1);
            end
            @(negedge clk);
            bus.req = '1;
            for (int n = 1; n < 200 && k < 8; n++) begin
                @(negedge clk);
                bus.req      = bus.req | drop;
                drop         = '0;
                bus.en_write = beat_next;
                beat_next    = bus.mst_begin;
                if (bus.mst_begin) begin
                    check("rr grant cur_ch", bus.cur_ch, k % NCH);
                    if (k > 0) check("rr done-to-launch gap", n - last_done_n, 2);
                end
                if (bus.done != '0) begin
                    check("rr done onehot", $onehot(bus.done), 1);
                    idx = 0;
                    for (int j = 0; j < NCH; j++) if (bus.done[j]) idx = j;
                    check("rr done order", idx, k % NCH);
                    bus.req     = bus.req & ~bus.done;
                    drop        = bus.done;
                    last_done_n = n;
                    k++;
                end
            end
            check("rr jobs completed", k, 8);
            bus.req      = '0;
            bus.en_write = 1'b0;
        end

        // Single channel holding req through done: its immediate re-grant is masked one cycle.
        repeat (4) @(negedge clk);
        begin
            int k, last_done_n;
            bit beat_next;
            k = 0; last_done_n = 0; beat_next = 0;
            bus.req = 4'b0001;
            for (int n = 1; n < 100 && k < 2; n++) begin
                @(negedge clk);
                bus.en_write = beat_next;
                beat_next    = bus.mst_begin;
                if (bus.mst_begin && k == 1) check("mask done-to-launch gap", n - last_done_n, 3);
                if (bus.done != '0) begin
                    check("mask done", bus.done, 4'b0001);
                    last_done_n = n;
                    k++;
                end
            end
            check("mask jobs completed", k, 2);
            bus.req      = '0;
            bus.en_write = 1'b0;
        end

        // Reset mid-BUSY: outputs clear asynchronously and rr_ptr restarts at 0.
        do_reset();
        bus.req_addr[2*AW +: AW] = 32'hCAFE_0000;
        bus.req_len[2*16 +: 16]  = 16'd100;
        bus.req[2]               = 1'b1;
        repeat (4) @(negedge clk);
        check("pre-reset busy", bus.busy, 1);
        check("pre-reset cur_ch", bus.cur_ch, 2);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset busy",      bus.busy, 0);
        check("mid reset cur_ch",    bus.cur_ch, 0);
        check("mid reset addr_src",  bus.addr_src, 0);
        check("mid reset data_len",  bus.data_len, 0);
        check("mid reset done",      bus.done, 0);
        check("mid reset mst_begin", bus.mst_begin, 0);
        bus.req                  = 4'b1001;
        bus.req_len[0*16 +: 16]  = 16'd4;
        bus.req_len[3*16 +: 16]  = 16'd4;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post reset mst_begin", bus.mst_begin, 1);
        check("post reset cur_ch", bus.cur_ch, 0);
        bus.req = '0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
